// File: rtl/smem_result_collector.sv
// Consumes the SMEM result stream from the curr/mem queue output port, checks read
// framing, buffers lines in a small FIFO and writes them to host line addresses.
module smem_result_collector #(
    parameter int READ_NUM_WIDTH = 8,
    parameter int FIFO_AW        = 4,
    parameter int STALL_SLACK    = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [READ_NUM_WIDTH:0] batch_size,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic                    output_request,
    output logic                    output_permit,
    input  logic [511:0]            output_data,
    input  logic                    output_valid,
    input  logic                    output_finish,
    output logic                    stall,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [511:0]            wr_data,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic                    done,
    output logic [15:0]             lines_written,
    output logic                    proto_error,
    output logic [1:0]              error_code
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int RW    = READ_NUM_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - STALL_SLACK);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_READ_NUM = 2'd1;
    localparam logic [1:0] ERR_COUNT    = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REQ = 3'd1,
        ST_GRANT    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Data lines following a header: ceil(mem_size/2) in 8-bit arithmetic.
    function automatic logic [7:0] lines_for_mem_size(input logic [6:0] mem_size);
        logic [7:0] sum;
        sum = {1'b0, mem_size} + 8'd1;
        return {1'b0, sum[7:1]};
    endfunction

    state_t              state_r, state_s;
    logic [511:0]        fifo_mem_r [DEPTH];
    logic [FIFO_AW-1:0]  wp_r, rp_r;
    logic [CW-1:0]       count_r, count_s;
    logic [RW-1:0]       batch_r, exp_num_r, exp_num_s;
    logic [7:0]          rem_r, rem_s;
    logic                exp_hdr_r, exp_hdr_s;
    logic [1:0]          line_err_s, err_s;
    logic                start_s, accept_s, full_s, push_s, pop_s;
    logic                permit_r, stall_r, valid_r, done_r, proto_r;
    logic [1:0]          code_r;
    logic [15:0]         lw_r;
    logic [ADDR_WIDTH-1:0] addr_r;

    assign start_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign accept_s = (state_r == ST_GRANT) && output_valid;
    assign full_s   = (count_r == FULL_CNT);
    assign push_s   = accept_s && !full_s;
    assign pop_s    = valid_r && wr_ready;

    // Next-state logic for the batch sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: if (start_s) state_s = ST_WAIT_REQ; else state_s = state_r;
            ST_WAIT_REQ:      if (output_request) state_s = ST_GRANT; else state_s = state_r;
            ST_GRANT:         if (output_finish) state_s = ST_DRAIN; else state_s = state_r;
            ST_DRAIN:         if (count_r == {CW{1'b0}}) state_s = ST_DONE; else state_s = state_r;
            default:          state_s = ST_IDLE;
        endcase
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_s = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_s = count_r - CW'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Framing tracker: dropped lines still advance framing so later lines stay aligned.
    always_comb begin
        exp_hdr_s  = exp_hdr_r;
        rem_s      = rem_r;
        exp_num_s  = exp_num_r;
        line_err_s = ERR_NONE;
        if (accept_s) begin
            if (exp_hdr_r) begin
                if (output_data[9:0] != 10'(exp_num_r)) begin
                    line_err_s = ERR_READ_NUM;
                end else begin
                    line_err_s = ERR_NONE;
                end
                rem_s = lines_for_mem_size(output_data[70:64]);
            end else begin
                rem_s = rem_r - 8'd1;
            end
            if (rem_s == 8'd0) begin
                exp_num_s = exp_num_r + RW'(1);
                exp_hdr_s = 1'b1;
            end else begin
                exp_hdr_s = 1'b0;
            end
        end else begin
            exp_hdr_s = exp_hdr_r;
        end
    end

    // Error classification for this cycle; the sticky register keeps only the first.
    always_comb begin
        err_s = ERR_NONE;
        if (accept_s && full_s) begin
            err_s = ERR_OVERFLOW;
        end else if (line_err_s != ERR_NONE) begin
            err_s = line_err_s;
        end else if ((state_r == ST_GRANT) && output_finish &&
                     ((exp_num_s != batch_r) || (rem_s != 8'd0))) begin
            err_s = ERR_COUNT;
        end else begin
            err_s = ERR_NONE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_s;
    end

    // Batch setup and framing registers; framing restarts on each grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            batch_r   <= {RW{1'b0}};
            exp_num_r <= {RW{1'b0}};
            rem_r     <= 8'd0;
            exp_hdr_r <= 1'b0;
        end else begin
            if (start_s) batch_r <= batch_size;
            if ((state_r == ST_WAIT_REQ) && output_request) begin
                exp_num_r <= {RW{1'b0}};
                rem_r     <= 8'd0;
                exp_hdr_r <= 1'b1;
            end else begin
                exp_num_r <= exp_num_s;
                rem_r     <= rem_s;
                exp_hdr_r <= exp_hdr_s;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_r    <= {FIFO_AW{1'b0}};
            rp_r    <= {FIFO_AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) wp_r <= wp_r + FIFO_AW'(1);
            if (pop_s)  rp_r <= rp_r + FIFO_AW'(1);
            count_r <= count_s;
        end
    end

    // Line storage; the head entry is never overwritten while it is presented.
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wp_r] <= output_data;
    end

    // Registered handshake and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            permit_r <= 1'b0;
            stall_r  <= 1'b0;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
            proto_r  <= 1'b0;
            code_r   <= ERR_NONE;
            lw_r     <= 16'd0;
            addr_r   <= {ADDR_WIDTH{1'b0}};
        end else begin
            permit_r <= (state_s == ST_GRANT);
            stall_r  <= (count_s >= STALL_CNT);
            valid_r  <= (count_s != {CW{1'b0}});
            if (start_s) begin
                done_r  <= 1'b0;
                proto_r <= 1'b0;
                code_r  <= ERR_NONE;
                lw_r    <= 16'd0;
                addr_r  <= base_addr;
            end else begin
                if ((state_r == ST_DRAIN) && (state_s == ST_DONE)) done_r <= 1'b1;
                if (!proto_r && (err_s != ERR_NONE)) begin
                    proto_r <= 1'b1;
                    code_r  <= err_s;
                end
                // Address tracks base + lines_written, so it freezes with the saturated count.
                if (pop_s && (lw_r != 16'hFFFF)) begin
                    lw_r   <= lw_r + 16'd1;
                    addr_r <= addr_r + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign output_permit = permit_r;
    assign stall         = stall_r;
    assign wr_valid      = valid_r;
    assign wr_data       = fifo_mem_r[rp_r];
    assign wr_addr       = addr_r;
    assign done          = done_r;
    assign lines_written = lw_r;
    assign proto_error   = proto_r;
    assign error_code    = code_r;

endmodule

// File: tb/tb_smem_result_collector.sv
// Directed and randomized batches against a queue-based scoreboard of the expected
// host writes, framing errors and backpressure level.
module tb_smem_result_collector;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [8:0]   batch_size;
    logic [31:0]  base_addr;
    logic         output_request;
    logic         output_permit;
    logic [511:0] output_data;
    logic         output_valid;
    logic         output_finish;
    logic         stall;
    logic [31:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_valid;
    logic         wr_ready;
    logic         done;
    logic [15:0]  lines_written;
    logic         proto_error;
    logic [1:0]   error_code;

    smem_result_collector dut (
        .clk(clk), .reset_n(reset_n), .start(start), .batch_size(batch_size),
        .base_addr(base_addr), .output_request(output_request),
        .output_permit(output_permit), .output_data(output_data),
        .output_valid(output_valid), .output_finish(output_finish), .stall(stall),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .done(done), .lines_written(lines_written), .proto_error(proto_error),
        .error_code(error_code)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [511:0] stream[$];
    logic [511:0] got_data[$];
    logic [31:0]  got_addr[$];
    logic         hold_pend = 1'b0;
    logic [511:0] hold_data;
    logic [31:0]  hold_addr;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic ready_val(input int rmode);
        if (rmode == 0) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add_read(input int rn, input int ms, input int nd);
        logic [511:0] h;
        h = rand_line();
        h[9:0]   = 10'(rn);
        h[70:64] = 7'(ms);
        stream.push_back(h);
        repeat (nd) stream.push_back(rand_line());
    endtask

    // Host side: record retired lines and check the write channel holds while stalled.
    always @(posedge clk) begin
        if (!reset_n) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", wr_valid, 1'b1);
                check("hold_data", wr_data, hold_data);
                check("hold_addr", wr_addr, hold_addr);
            end
            if (wr_valid && wr_ready) begin
                got_data.push_back(wr_data);
                got_addr.push_back(wr_addr);
            end
            hold_pend <= wr_valid && !wr_ready;
            hold_data <= wr_data;
            hold_addr <= wr_addr;
        end
    end

    // One batch: start, grant, send the stream, finish, drain, then score.
    task automatic play(input int bsz, input logic [31:0] base, input int rmode, input int hold,
                        input bit ign_stall, input int exp_err, input int n_exp);
        int sent;
        int cyc;
        got_data.delete();
        got_addr.delete();
        @(negedge clk);
        start = 1'b1; batch_size = 9'(bsz); base_addr = base; wr_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; output_request = 1'b1;
        check("done_clr", done, 1'b0);
        check("lw_clr", lines_written, 16'd0);
        check("err_clr", {proto_error, error_code}, 3'd0);
        cyc = 0;
        while (!output_permit && cyc < 20) begin @(negedge clk); cyc++; end
        check("permit_wait", output_permit, 1'b1);
        sent = 0; cyc = 0;
        while (sent < stream.size() && cyc < 2000) begin
            output_valid = 1'b0;
            if (hold > 0 && cyc < hold) begin
                check($sformatf("stall_lvl[%0d]", cyc), stall, (sent >= 12));
                wr_ready = 1'b0;
            end else begin
                wr_ready = ready_val(rmode);
            end
            if (ign_stall || !stall) begin
                output_valid = 1'b1;
                output_data  = stream[sent];
                sent++;
            end
            @(negedge clk); cyc++;
        end
        check("send_all", sent, stream.size());
        output_valid = 1'b0; output_finish = 1'b1; wr_ready = ready_val(rmode);
        @(negedge clk);
        output_finish = 1'b0; output_request = 1'b0;
        check("permit_drop", output_permit, 1'b0);
        cyc = 0;
        while (!done && cyc < 500) begin
            wr_ready = ready_val(rmode);
            @(negedge clk); cyc++;
        end
        wr_ready = 1'b0;
        check("done", done, 1'b1);
        check("lines_written", lines_written, n_exp);
        check("proto_error", proto_error, (exp_err != 0));
        check("error_code", error_code, exp_err);
        check("n_lines", got_data.size(), n_exp);
        for (int i = 0; i < n_exp && i < got_data.size(); i++) begin
            check($sformatf("data[%0d]", i), got_data[i], stream[i]);
            check($sformatf("addr[%0d]", i), got_addr[i], 32'(base + 32'(i)));
        end
        check("end_wr_valid", wr_valid, 1'b0);
        check("end_stall", stall, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr;
        int ms;
        int rm;
        reset_n = 1'b0; start = 1'b0; batch_size = 9'd0; base_addr = 32'd0;
        output_request = 1'b0; output_data = '0; output_valid = 1'b0;
        output_finish = 1'b0; wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_permit", output_permit, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_lw", lines_written, 16'd0);
        check("rst_err", {proto_error, error_code}, 3'd0);
        reset_n = 1'b1;

        // Basic two-read batch at 0x100.
        stream.delete(); add_read(0, 3, 2); add_read(1, 0, 0);
        play(2, 32'h100, 0, 0, 1'b0, 0, 4);

        // Host blocked for 20 cycles: stall rises at 12, nothing lost.
        stream.delete(); add_read(0, 27, 14);
        play(1, $urandom(), 0, 20, 1'b0, 0, 15);

        // Read-number mismatch.
        stream.delete(); add_read(0, 1, 1); add_read(2, 0, 0);
        play(2, $urandom(), 0, 0, 1'b0, 1, 3);

        // Short read: header mem_size 4 with a single data line.
        stream.delete(); add_read(0, 4, 1); add_read(1, 0, 0);
        play(2, $urandom(), 2, 0, 1'b0, 2, 3);

        // Overflow: 17 lines into a blocked 16-entry FIFO.
        stream.delete(); add_read(0, 31, 16);
        play(1, $urandom(), 0, 40, 1'b1, 3, 16);

        // Reset mid-grant.
        @(negedge clk);
        start = 1'b1; batch_size = 9'd1; base_addr = 32'h40;
        @(negedge clk);
        start = 1'b0; output_request = 1'b1;
        for (int c = 0; c < 20 && !output_permit; c++) @(negedge clk);
        check("mid_permit", output_permit, 1'b1);
        for (int k = 0; k < 13; k++) begin
            output_valid = 1'b1; output_data = rand_line(); wr_ready = 1'b0;
            @(negedge clk);
        end
        output_valid = 1'b0;
        check("mid_stall", stall, 1'b1);
        check("mid_wr_valid", wr_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst_permit", output_permit, 1'b0);
        check("arst_stall", stall, 1'b0);
        check("arst_wr_valid", wr_valid, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_lw", lines_written, 16'd0);
        @(negedge clk);
        reset_n = 1'b1; output_request = 1'b0;

        // Randomized well-framed batches with random host readiness.
        for (int b = 0; b < 5; b++) begin
            stream.delete();
            nr = $urandom_range(1, 4);
            for (int r = 0; r < nr; r++) begin
                ms = $urandom_range(0, 12);
                add_read(r, ms, (ms + 1) / 2);
            end
            rm = ($urandom_range(0, 1) == 1) ? 2 : 0;
            play(nr, $urandom(), rm, 0, 1'b0, 0, stream.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
